// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall sequencing and taken-branch squash control
// for a five-stage MIPS pipeline. Outputs are Mealy functions of the current
// state and inputs.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// stallCount / flushCount performance counters and their ports.

module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1   // bubbles per load-use hazard, 1..3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRt,
    input  logic        exMemRead,
    input  logic [4:0]  exRt,
    input  logic        memBranchTaken,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        exMemFlush,
    output logic        stalled
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Which family of control values the pipeline sees this cycle.
    typedef enum logic [1:0] {
        OUT_RUN,
        OUT_STALL,
        OUT_FLUSH,
        OUT_RESET
    } out_mode_e;

    // Stall cycles still owed after the detection cycle.
    localparam logic [1:0] REMAIN_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] remain_q, remain_d;
    out_mode_e  out_mode;
    logic       hz;

    // Load-use hazard: the load in ID/EX writes a register the IF/ID
    // instruction reads. Register 0 is hardwired and never conflicts.
    assign hz = exMemRead && (exRt != 5'd0) &&
                ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

    // Next-state and output-mode selection; reset, then branch, take priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        remain_d = remain_q;
        out_mode = OUT_RUN;

        if (rst) begin
            out_mode = OUT_RESET;
            state_d  = ST_RUN;
            remain_d = 2'd0;
        end else if (memBranchTaken) begin
            // The stalled instruction is wrong-path; abandon the stall.
            out_mode = OUT_FLUSH;
            state_d  = ST_RUN;
            remain_d = 2'd0;
        end else if (state_q == ST_STALL) begin
            out_mode = OUT_STALL;
            if (remain_q <= 2'd1) begin
                state_d  = ST_RUN;
                remain_d = 2'd0;
            end else begin
                remain_d = remain_q - 2'd1;
            end
        end else if (hz) begin
            out_mode = OUT_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d  = ST_STALL;
                remain_d = REMAIN_INIT;
            end
        end
    end

    // Decode the output mode into the individual pipeline controls.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        exMemFlush = 1'b0;
        stalled    = 1'b0;
        case (out_mode)
            OUT_STALL: begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExBubble = 1'b1;
                stalled    = 1'b1;
            end
            OUT_FLUSH: begin
                ifIdFlush  = 1'b1;
                idExBubble = 1'b1;
                exMemFlush = 1'b1;
            end
            OUT_RESET: begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                ifIdFlush  = 1'b1;
                idExBubble = 1'b1;
                exMemFlush = 1'b1;
            end
            default: ;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q  <= ST_RUN;
            remain_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters; stalled is already 0 while in reset.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stalled && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (memBranchTaken && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: drives three hazard_controller instances
// (LOAD_STALL_CYCLES = 1, 2, 3) with shared inputs. A behavioural model that
// counts owed stall cycles predicts every instance's outputs each cycle;
// directed scenarios add literal expectations, then random traffic follows.

module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, mem_branch_taken;

    logic [2:0]  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, stalled;
`ifdef HAZARD_PERF_CNT_EN
    logic [2:0][31:0] stall_cnt, flush_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Output bundle order: {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush, stalled}
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000101;
    localparam logic [5:0] O_FLUSH = 6'b111110;
    localparam logic [5:0] O_RESET = 6'b001110;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_controller #(.LOAD_STALL_CYCLES(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .idRs           (id_rs),
            .idRt           (id_rt),
            .idUsesRt       (id_uses_rt),
            .exMemRead      (ex_mem_read),
            .exRt           (ex_rt),
            .memBranchTaken (mem_branch_taken),
            .pcWrite        (pc_write[g]),
            .ifIdWrite      (if_id_write[g]),
            .ifIdFlush      (if_id_flush[g]),
            .idExBubble     (id_ex_bubble[g]),
            .exMemFlush     (ex_mem_flush[g]),
            .stalled        (stalled[g])
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stallCount     (stall_cnt[g]),
            .flushCount     (flush_cnt[g])
`endif
        );
    end

    function automatic logic [5:0] dut_out(input int i);
        return {pc_write[i], if_id_write[i], if_id_flush[i],
                id_ex_bubble[i], ex_mem_flush[i], stalled[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model + per-cycle comparison -------------
    int          owed [3] = '{0, 0, 0};   // stall cycles still owed after this one
    logic [31:0] m_stall_cnt [3] = '{0, 0, 0};
    logic [31:0] m_flush_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        logic       hz_m;
        logic [5:0] exp;
        hz_m = ex_mem_read && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp = O_RESET;
            end else if (mem_branch_taken) begin
                exp = O_FLUSH;
            end else if (owed[i] > 0 || hz_m) begin
                exp = O_STALL;
            end else begin
                exp = O_RUN;
            end
            check($sformatf("outputs_lsc%0d", i + 1), 32'(dut_out(i)), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
            check($sformatf("stall_count_lsc%0d", i + 1), stall_cnt[i], m_stall_cnt[i]);
            check($sformatf("flush_count_lsc%0d", i + 1), flush_cnt[i], m_flush_cnt[i]);
`endif
            // Advance the model to the next cycle.
            if (rst || mem_branch_taken) owed[i] = 0;
            else if (owed[i] > 0)        owed[i] = owed[i] - 1;
            else if (hz_m)               owed[i] = i;   // LOAD_STALL_CYCLES - 1
            if (rst) begin
                m_stall_cnt[i] = 0;
                m_flush_cnt[i] = 0;
            end else begin
                if (exp[0] && m_stall_cnt[i] != 32'hFFFF_FFFF) m_stall_cnt[i]++;
                if (mem_branch_taken && m_flush_cnt[i] != 32'hFFFF_FFFF) m_flush_cnt[i]++;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    // Called just after a rising edge; returns mid-cycle with inputs settled.
    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic mr, input logic [4:0] xrt,
                         input logic br);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_mem_read = mr; ex_rt = xrt; mem_branch_taken = br;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs = 5'd8; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd8; mem_branch_taken = 1'b0;
        #1;

        // Reset held two cycles with a hazard present.
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
            check("reset_outputs", 32'(dut_out(2)), 32'(O_RESET));
            next_cycle();
        end
        idle();
        check("after_reset_run", 32'(dut_out(0)), 32'(O_RUN));
        next_cycle();

        // Load-use: one stall for LSC=1, two for LSC=2, three for LSC=3.
        drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        check("load_use_lsc1", 32'(dut_out(0)), 32'(O_STALL));
        next_cycle();
        idle();
        check("load_use_lsc1_release", 32'(dut_out(0)), 32'(O_RUN));
        check("load_use_lsc2_second", 32'(dut_out(1)), 32'(O_STALL));
        next_cycle();
        idle();
        check("load_use_lsc2_release", 32'(dut_out(1)), 32'(O_RUN));
        check("load_use_lsc3_third", 32'(dut_out(2)), 32'(O_STALL));
        next_cycle();
        idle();
        check("load_use_lsc3_release", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();

        // Non-hazards.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        check("no_hz_reg0", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();
        drive(1'b0, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0);
        check("no_hz_rt_unused", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();
        drive(1'b0, 5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0);
        check("no_hz_not_load", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();
        drive(1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0);
        check("hz_via_rt", 32'(dut_out(0)), 32'(O_STALL));
        next_cycle();
        for (int c = 0; c < 3; c++) begin idle(); next_cycle(); end

        // Branch coincident with a hazard wins.
        drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        check("branch_over_hz", 32'(dut_out(2)), 32'(O_FLUSH));
        next_cycle();
        idle();
        check("branch_over_hz_after", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();

        // Branch in the second stall cycle of LSC=3 ends the stall.
        drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        next_cycle();
        drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
        check("branch_in_stall", 32'(dut_out(2)), 32'(O_FLUSH));
        next_cycle();
        idle();
        check("branch_in_stall_run", 32'(dut_out(2)), 32'(O_RUN));
        next_cycle();

`ifdef HAZARD_PERF_CNT_EN
        // Counter scenario on the LSC=1 instance.
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        next_cycle();
        idle();
        next_cycle();
        drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
        next_cycle();
        idle();
        check("perf_stall_count", stall_cnt[0], 32'd1);
        check("perf_flush_count", flush_cnt[0], 32'd1);
        next_cycle();
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
        next_cycle();
        idle();
        check("perf_stall_cleared", stall_cnt[0], 32'd0);
        check("perf_flush_cleared", flush_cnt[0], 32'd0);
        next_cycle();
`endif

        // Random traffic; small register range makes hazards frequent.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0));
            next_cycle();
        end

        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
